// File: rtl/lu_memory_unit.sv
// LU-stage memory unit: a direct-mapped, one-word-per-line cache in front of a req/ack
// memory port. Stores are write-through without allocation; results go to the ROB.
//
// state | meaning
// IDLE  | LU instruction evaluated; bubbles, non-memory ops and load hits finish here
// BUSY  | memory request outstanding, waiting for mem_ack
module lu_memory_unit #(
    parameter int LINES             = 4,
    parameter int DATA_SIZE         = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MODE_WIDTH        = 4,
    parameter int ROB_WIDTH         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_LU,
    input  logic [MODE_WIDTH-1:0]        mode_LU,
    input  logic [DATA_SIZE-1:0]         ALU_out_LU,
    input  logic [ROB_WIDTH-1:0]         tag_LU,
    input  logic [DATA_SIZE-1:0]         rs_bus_LU,
    input  logic                         flush,
    output logic                         stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [DATA_SIZE-1:0]         mem_addr,
    output logic [DATA_SIZE-1:0]         mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_SIZE-1:0]         mem_rdata,
    output logic                         wb_valid,
    output logic [ROB_WIDTH-1:0]         wb_tag,
    output logic [DATA_SIZE-1:0]         wb_data,
    output logic [INSTRUCTION_WIDTH-1:0] wb_instruction
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = DATA_SIZE - 2 - IDX_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                       state;
    logic [LINES-1:0]             line_valid;
    logic [TAG_W-1:0]             line_tag  [LINES];
    logic [DATA_SIZE-1:0]         line_data [LINES];
    logic [ROB_WIDTH-1:0]         pend_tag;
    logic [INSTRUCTION_WIDTH-1:0] pend_instruction;

    logic             is_bubble, is_load, is_store;
    logic [IDX_W-1:0] lu_idx, req_idx;
    logic [TAG_W-1:0] lu_tag, req_tag;
    logic             lu_hit, req_hit;
    logic             unused_mode;

    assign is_bubble   = (instruction_LU == '0);
    assign is_load     = !is_bubble && (mode_LU[1:0] == 2'b01);
    assign is_store    = !is_bubble && (mode_LU[1:0] == 2'b10);
    assign unused_mode = ^mode_LU;

    assign lu_idx  = ALU_out_LU[2 +: IDX_W];
    assign lu_tag  = ALU_out_LU[DATA_SIZE-1 -: TAG_W];
    assign req_idx = mem_addr[2 +: IDX_W];
    assign req_tag = mem_addr[DATA_SIZE-1 -: TAG_W];
    assign lu_hit  = line_valid[lu_idx] && (line_tag[lu_idx] == lu_tag);
    assign req_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    // The ack cycle releases the stall so the next instruction lands with no dead cycle.
    always_comb begin
        stall = 1'b0;
        if (state == BUSY)
            stall = !mem_ack;
        else if (is_store || (is_load && !lu_hit))
            stall = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            line_valid       <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            wb_valid         <= 1'b0;
            wb_tag           <= '0;
            wb_data          <= '0;
            wb_instruction   <= '0;
            pend_tag         <= '0;
            pend_instruction <= '0;
            for (int i = 0; i < LINES; i++) begin
                line_tag[i]  <= '0;
                line_data[i] <= '0;
            end
        end else begin
            wb_valid <= 1'b0;
            if (flush)
                line_valid <= '0;

            if (state == IDLE) begin
                if (is_load && lu_hit) begin
                    wb_valid       <= 1'b1;
                    wb_data        <= line_data[lu_idx];
                    wb_tag         <= tag_LU;
                    wb_instruction <= instruction_LU;
                end else if (is_load || is_store) begin
                    state            <= BUSY;
                    mem_req          <= 1'b1;
                    mem_we           <= is_store;
                    mem_addr         <= ALU_out_LU;
                    pend_tag         <= tag_LU;
                    pend_instruction <= instruction_LU;
                    if (is_store)
                        mem_wdata <= rs_bus_LU;
                end else if (!is_bubble) begin
                    wb_valid       <= 1'b1;
                    wb_data        <= ALU_out_LU;
                    wb_tag         <= tag_LU;
                    wb_instruction <= instruction_LU;
                end
            end else if (mem_ack) begin
                state          <= IDLE;
                mem_req        <= 1'b0;
                mem_we         <= 1'b0;
                wb_valid       <= 1'b1;
                wb_tag         <= pend_tag;
                wb_instruction <= pend_instruction;
                // A flush landing on the completion edge wins over any line update.
                if (!mem_we) begin
                    wb_data <= mem_rdata;
                    if (!flush) begin
                        line_valid[req_idx] <= 1'b1;
                        line_tag[req_idx]   <= req_tag;
                        line_data[req_idx]  <= mem_rdata;
                    end
                end else begin
                    wb_data <= '0;
                    if (req_hit && !flush)
                        line_data[req_idx] <= mem_wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_lu_memory_unit.sv
// Bench for lu_memory_unit: directed scenarios plus a randomized run checked against
// an array-based cache model driven by a req/ack memory responder.
module tb_lu_memory_unit;
    localparam int LINES = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_LU = '0;
    logic [3:0]  mode_LU = '0;
    logic [31:0] ALU_out_LU = '0;
    logic [3:0]  tag_LU = '0;
    logic [31:0] rs_bus_LU = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data, wb_instruction;

    lu_memory_unit #(
        .LINES(LINES), .DATA_SIZE(32), .INSTRUCTION_WIDTH(32), .MODE_WIDTH(4), .ROB_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .instruction_LU(instruction_LU), .mode_LU(mode_LU),
        .ALU_out_LU(ALU_out_LU), .tag_LU(tag_LU), .rs_bus_LU(rs_bus_LU), .flush(flush),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_instruction(wb_instruction)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Observations of the last operation driven through do_op.
    int          stall_cyc;
    bit          req_seen, unstable;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic        o_wbv;
    logic [3:0]  o_wbt;
    logic [31:0] o_wbd, o_wbi;

    // Reference cache model.
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES];

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a / 4) % LINES;
    endfunction

    function automatic int unsigned m_tg(input logic [31:0] a);
        return a / (4 * LINES);
    endfunction

    // Upstream + memory driver: holds the op while stalled, acks after ack_delay request
    // cycles, raises flush in the completing cycle. Called and returns at posedge+1.
    task automatic do_op(input logic [31:0] instr, input logic [3:0] mode, input logic [31:0] addr,
                         input logic [3:0] tag, input logic [31:0] wdata, input int ack_delay,
                         input bit flush_req, input logic [31:0] rdata);
        int req_cyc;
        bit done;
        instruction_LU = instr; mode_LU = mode; ALU_out_LU = addr; tag_LU = tag; rs_bus_LU = wdata;
        stall_cyc = 0; req_seen = 0; unstable = 0; req_cyc = 0; done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            #4;
            if (mem_req) begin
                if (!req_seen) begin
                    cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    unstable = 1;
                end
                req_seen = 1;
                req_cyc++;
                if (req_cyc > ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
            end
            #1;
            if (stall === 1'b0) begin
                done = 1; flush = flush_req;
            end else begin
                stall_cyc++;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; flush = 1'b0;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL op_timeout: addr %0h still stalled after 64 cycles, want completion", addr);
        end
        o_wbv = wb_valid; o_wbt = wb_tag; o_wbd = wb_data; o_wbi = wb_instruction;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_tag, wb_data, wb_instruction} !== '0) begin n_fail++; $display("FAIL reset_regs: got %0h want 0", {mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_tag, wb_data, wb_instruction}); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_bubble: got %b want 0", stall); end
        instruction_LU = 32'h23; mode_LU = 4'b0010;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_store: got %b want 1", stall); end
        instruction_LU = '0; mode_LU = '0;
        #9 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        do_op(32'h13, 4'b0100, 32'h1234, 4'd3, 32'h0, 0, 0, 32'h0);
        n_cmp++; if (stall_cyc !== 0) begin n_fail++; $display("FAIL nonmem_stall: got %0d want 0", stall_cyc); end
        n_cmp++; if (o_wbv !== 1'b1) begin n_fail++; $display("FAIL nonmem_valid: got %b want 1", o_wbv); end
        n_cmp++; if (o_wbd !== 32'h1234) begin n_fail++; $display("FAIL nonmem_data: got %0h want 1234", o_wbd); end
        n_cmp++; if (o_wbt !== 4'd3) begin n_fail++; $display("FAIL nonmem_tag: got %0d want 3", o_wbt); end
        n_cmp++; if (o_wbi !== 32'h13) begin n_fail++; $display("FAIL nonmem_instr: got %0h want 13", o_wbi); end
        n_cmp++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL nonmem_req: got %b want 0", req_seen); end
        do_op(32'h0, 4'b0001, 32'h40, 4'd9, 32'h0, 0, 0, 32'h0);
        n_cmp++; if (o_wbv !== 1'b0 || stall_cyc !== 0) begin n_fail++; $display("FAIL bubble_valid: got wbv %b stall %0d want 0 0", o_wbv, stall_cyc); end
        n_cmp++; if (o_wbd !== 32'h1234 || o_wbt !== 4'd3) begin n_fail++; $display("FAIL bubble_hold: got %0h/%0d want 1234/3", o_wbd, o_wbt); end
    endtask

    task automatic test_load();
        do_op(32'h0, 4'b0000, 32'h0, 4'd0, 32'h0, 0, 1, 32'h0);
        do_op(32'h03, 4'b0001, 32'h40, 4'd5, 32'h0, 3, 0, 32'hDEAD);
        n_cmp++; if (stall_cyc !== 4) begin n_fail++; $display("FAIL load_miss_stall: got %0d want 4", stall_cyc); end
        n_cmp++; if (cap_addr !== 32'h40 || cap_we !== 1'b0) begin n_fail++; $display("FAIL load_miss_req: got addr %0h we %b want 40 0", cap_addr, cap_we); end
        n_cmp++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL load_req_stable: got %b want 0", unstable); end
        n_cmp++; if (o_wbv !== 1'b1 || o_wbd !== 32'hDEAD || o_wbt !== 4'd5) begin n_fail++; $display("FAIL load_miss_wb: got %b/%0h/%0d want 1/dead/5", o_wbv, o_wbd, o_wbt); end
        do_op(32'h03, 4'b0001, 32'h40, 4'd6, 32'h0, 3, 0, 32'h1111);
        n_cmp++; if (stall_cyc !== 0 || req_seen !== 1'b0) begin n_fail++; $display("FAIL load_hit_nomem: got stall %0d req %b want 0 0", stall_cyc, req_seen); end
        n_cmp++; if (o_wbv !== 1'b1 || o_wbd !== 32'hDEAD || o_wbt !== 4'd6) begin n_fail++; $display("FAIL load_hit_wb: got %b/%0h/%0d want 1/dead/6", o_wbv, o_wbd, o_wbt); end
    endtask

    task automatic test_store();
        do_op(32'h23, 4'b0010, 32'h40, 4'd7, 32'hBEEF, 1, 0, 32'h0);
        n_cmp++; if (stall_cyc !== 2) begin n_fail++; $display("FAIL store_stall: got %0d want 2", stall_cyc); end
        n_cmp++; if (cap_we !== 1'b1 || cap_wdata !== 32'hBEEF || cap_addr !== 32'h40) begin n_fail++; $display("FAIL store_req: got we %b data %0h addr %0h want 1 beef 40", cap_we, cap_wdata, cap_addr); end
        n_cmp++; if (o_wbv !== 1'b1 || o_wbd !== 32'h0 || o_wbt !== 4'd7) begin n_fail++; $display("FAIL store_wb: got %b/%0h/%0d want 1/0/7", o_wbv, o_wbd, o_wbt); end
        do_op(32'h03, 4'b0001, 32'h40, 4'd1, 32'h0, 0, 0, 32'h2222);
        n_cmp++; if (stall_cyc !== 0 || o_wbd !== 32'hBEEF) begin n_fail++; $display("FAIL store_then_hit: got stall %0d data %0h want 0 beef", stall_cyc, o_wbd); end
        do_op(32'h23, 4'b0010, 32'h80, 4'd2, 32'h5555, 0, 0, 32'h0);
        n_cmp++; if (stall_cyc !== 1 || o_wbd !== 32'h0) begin n_fail++; $display("FAIL store_uncached: got stall %0d data %0h want 1 0", stall_cyc, o_wbd); end
        do_op(32'h03, 4'b0001, 32'h40, 4'd1, 32'h0, 0, 0, 32'h3333);
        n_cmp++; if (req_seen !== 1'b0 || o_wbd !== 32'hBEEF) begin n_fail++; $display("FAIL store_no_alloc_line0: got req %b data %0h want 0 beef", req_seen, o_wbd); end
    endtask

    task automatic test_conflict();
        do_op(32'h0, 4'b0000, 32'h0, 4'd0, 32'h0, 0, 1, 32'h0);
        do_op(32'h03, 4'b0001, 32'h40, 4'd1, 32'h0, 0, 0, 32'hA1);
        do_op(32'h03, 4'b0001, 32'h50, 4'd2, 32'h0, 1, 0, 32'hB2);
        n_cmp++; if (req_seen !== 1'b1 || o_wbd !== 32'hB2) begin n_fail++; $display("FAIL conflict_second: got req %b data %0h want 1 b2", req_seen, o_wbd); end
        do_op(32'h03, 4'b0001, 32'h40, 4'd3, 32'h0, 0, 0, 32'hA3);
        n_cmp++; if (req_seen !== 1'b1 || cap_addr !== 32'h40 || o_wbd !== 32'hA3) begin n_fail++; $display("FAIL conflict_third: got req %b addr %0h data %0h want 1 40 a3", req_seen, cap_addr, o_wbd); end
    endtask

    task automatic test_flush_fill();
        do_op(32'h03, 4'b0001, 32'h60, 4'd4, 32'h0, 2, 1, 32'hCAFE);
        n_cmp++; if (o_wbv !== 1'b1 || o_wbd !== 32'hCAFE) begin n_fail++; $display("FAIL flush_fill_wb: got %b/%0h want 1/cafe", o_wbv, o_wbd); end
        do_op(32'h03, 4'b0001, 32'h60, 4'd5, 32'h0, 0, 0, 32'hCAFF);
        n_cmp++; if (req_seen !== 1'b1 || o_wbd !== 32'hCAFF) begin n_fail++; $display("FAIL flush_fill_reload: got req %b data %0h want 1 caff", req_seen, o_wbd); end
    endtask

    task automatic test_stray_ack();
        instruction_LU = '0; mode_LU = 4'b0001; ALU_out_LU = 32'h60;
        #4 mem_ack = 1'b1; mem_rdata = 32'h7777;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stray_ack_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_effect: got wbv %b req %b want 0 0", wb_valid, mem_req); end
        do_op(32'h03, 4'b0001, 32'h60, 4'd6, 32'h0, 0, 0, 32'h8888);
        n_cmp++; if (stall_cyc !== 0 || o_wbd !== 32'hCAFF) begin n_fail++; $display("FAIL stray_ack_cache: got stall %0d data %0h want 0 caff", stall_cyc, o_wbd); end
    endtask

    task automatic test_back_to_back();
        int unsigned t0, t1, t2, t3, t4;
        do_op(32'h03, 4'b0001, 32'h44, 4'd1, 32'h0, 0, 0, 32'h44AA);
        t0 = cyc;
        do_op(32'h33, 4'b0011, 32'h99, 4'd2, 32'h0, 0, 0, 32'h0);
        t1 = cyc;
        n_cmp++; if (t1 - t0 !== 1 || o_wbv !== 1'b1 || o_wbd !== 32'h99) begin n_fail++; $display("FAIL b2b_nonmem: got gap %0d wbv %b data %0h want 1 1 99", t1 - t0, o_wbv, o_wbd); end
        do_op(32'h03, 4'b0001, 32'h44, 4'd3, 32'h0, 0, 0, 32'h0);
        t2 = cyc;
        n_cmp++; if (t2 - t1 !== 1 || o_wbd !== 32'h44AA) begin n_fail++; $display("FAIL b2b_hit: got gap %0d data %0h want 1 44aa", t2 - t1, o_wbd); end
        do_op(32'h03, 4'b0001, 32'h48, 4'd4, 32'h0, 2, 0, 32'h48BB);
        t3 = cyc;
        n_cmp++; if (t3 - t2 !== 4 || o_wbd !== 32'h48BB) begin n_fail++; $display("FAIL b2b_miss: got gap %0d data %0h want 4 48bb", t3 - t2, o_wbd); end
        do_op(32'h33, 4'b0000, 32'h77, 4'd5, 32'h0, 0, 0, 32'h0);
        t4 = cyc;
        n_cmp++; if (t4 - t3 !== 1 || o_wbv !== 1'b1 || o_wbt !== 4'd5) begin n_fail++; $display("FAIL b2b_after_ack: got gap %0d wbv %b tag %0d want 1 1 5", t4 - t3, o_wbv, o_wbt); end
        do_op(32'h0, 4'b0000, 32'h0, 4'd0, 32'h0, 0, 0, 32'h0);
        n_cmp++; if (o_wbv !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got wbv %b want 0", o_wbv); end
    endtask

    task automatic test_reset_busy();
        do_op(32'h03, 4'b0001, 32'h40, 4'd1, 32'h0, 0, 0, 32'h4040);
        instruction_LU = 32'h03; mode_LU = 4'b0001; ALU_out_LU = 32'h80; tag_LU = 4'd2;
        @(posedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got req %b want 1", mem_req); end
        #3 reset = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_drop: got req %b wbv %b want 0 0", mem_req, wb_valid); end
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_busy_stall_inputs: got %b want 1", stall); end
        instruction_LU = '0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_busy_stall_bubble: got %b want 0", stall); end
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_busy_after: got wbv %b req %b want 0 0", wb_valid, mem_req); end
        do_op(32'h03, 4'b0001, 32'h40, 4'd3, 32'h0, 0, 0, 32'h4141);
        n_cmp++; if (req_seen !== 1'b1 || o_wbd !== 32'h4141) begin n_fail++; $display("FAIL rst_busy_reload: got req %b data %0h want 1 4141", req_seen, o_wbd); end
    endtask

    task automatic test_random();
        logic [31:0] instr, addr, wdata, rdata, exp_d, last_d;
        logic [3:0]  mode, tag, last_t;
        int          kind, dly, exp_stall;
        bit          fl, hit, exp_v, exp_req;
        int unsigned ix;
        do_op(32'h0, 4'b0000, 32'h0, 4'd0, 32'h0, 0, 1, 32'h0);
        do_op(32'h13, 4'b0000, 32'h5A5A, 4'd9, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        last_d = 32'h5A5A; last_t = 4'd9;
        for (int n = 0; n < 300; n++) begin
            kind  = $urandom_range(0, 3);
            addr  = 32'($urandom_range(0, 31)) * 4;
            instr = (kind == 0) ? 32'h0 : 32'($urandom_range(1, 32'hFFFF));
            tag   = 4'($urandom_range(0, 15));
            wdata = $urandom; rdata = $urandom;
            dly   = $urandom_range(0, 3);
            fl    = ($urandom_range(0, 7) == 0);
            case (kind)
                0: mode = 4'($urandom_range(0, 15));
                1: mode = {2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00};
                2: mode = {2'($urandom_range(0, 3)), 2'b01};
                default: mode = {2'($urandom_range(0, 3)), 2'b10};
            endcase
            ix  = m_idx(addr);
            hit = m_valid[ix] && (m_tag[ix] == m_tg(addr));
            exp_v = (kind != 0); exp_req = 0; exp_stall = 0; exp_d = last_d;
            if (kind == 1) exp_d = addr;
            if (kind == 2 && hit) exp_d = m_data[ix];
            if (kind == 2 && !hit) begin exp_req = 1; exp_stall = dly + 1; exp_d = rdata; end
            if (kind == 3) begin exp_req = 1; exp_stall = dly + 1; exp_d = 32'h0; end

            do_op(instr, mode, addr, tag, wdata, dly, fl, rdata);

            n_cmp++; if (stall_cyc !== exp_stall || req_seen !== exp_req) begin n_fail++; $display("FAIL rnd_timing[%0d]: got stall %0d req %b want %0d %b", n, stall_cyc, req_seen, exp_stall, exp_req); end
            n_cmp++; if (o_wbv !== exp_v || o_wbd !== exp_d) begin n_fail++; $display("FAIL rnd_wb[%0d]: got %b/%0h want %b/%0h", n, o_wbv, o_wbd, exp_v, exp_d); end
            n_cmp++; if (o_wbt !== (exp_v ? tag : last_t)) begin n_fail++; $display("FAIL rnd_tag[%0d]: got %0d want %0d", n, o_wbt, exp_v ? tag : last_t); end
            if (exp_v) begin
                n_cmp++; if (o_wbi !== instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %0h want %0h", n, o_wbi, instr); end
            end
            if (exp_req) begin
                n_cmp++; if (cap_addr !== addr || cap_we !== (kind == 3) || unstable !== 1'b0) begin n_fail++; $display("FAIL rnd_req[%0d]: got addr %0h we %b unstable %b want %0h %b 0", n, cap_addr, cap_we, unstable, addr, kind == 3); end
                if (kind == 3) begin
                    n_cmp++; if (cap_wdata !== wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %0h want %0h", n, cap_wdata, wdata); end
                end
            end

            if (kind == 2 && !hit) begin m_valid[ix] = 1; m_tag[ix] = m_tg(addr); m_data[ix] = rdata; end
            if (kind == 3 && hit) m_data[ix] = wdata;
            if (fl) for (int i = 0; i < LINES; i++) m_valid[i] = 0;
            if (exp_v) begin last_d = exp_d; last_t = tag; end
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_conflict();
        test_flush_fill();
        test_stray_ack();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
